// File: rtl/snn_pkg.sv
// Shared types and constants for the SNN sequencer: FSM state enum, command
// encodings, default parameter values and a class-index width helper.
package snn_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoadW,
        StLoadIn,
        StRun,
        StDone
    } state_e;

    localparam logic [1:0] CMD_LOAD_W  = 2'b00;
    localparam logic [1:0] CMD_LOAD_IN = 2'b01;
    localparam logic [1:0] CMD_RUN     = 2'b10;
    localparam logic [1:0] CMD_NOP     = 2'b11;

    localparam int unsigned DEF_INPUTS    = 16;
    localparam int unsigned DEF_W_BYTES   = 80;
    localparam int unsigned DEF_NUM_OUT   = 8;
    localparam int unsigned DEF_TIMESTEPS = 8;
    localparam int unsigned DEF_CNT_W     = 4;
    localparam int unsigned DEF_SETTLE    = 2;

    // Never returns 0 so a single-neuron build still has a legal class port.
    function automatic int unsigned cls_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/snn_sequencer_if.sv
// Command, byte-stream and result handshakes of the SNN sequencer.
// master = controller/host side, slave = the sequencer.
interface snn_sequencer_if
    import snn_pkg::*;
#(
    parameter int unsigned NUM_OUT = DEF_NUM_OUT,
    parameter int unsigned CNT_W   = DEF_CNT_W
);
    localparam int unsigned CLS_W = cls_width(NUM_OUT);

    logic             cmd_valid;
    logic [1:0]       cmd;
    logic             cmd_ready;
    logic             s_valid;
    logic [7:0]       s_data;
    logic             s_ready;
    logic             res_valid;
    logic             res_ready;
    logic [CLS_W-1:0] res_class;
    logic [CNT_W-1:0] res_count;

    modport master (
        output cmd_valid, cmd, s_valid, s_data, res_ready,
        input  cmd_ready, s_ready, res_valid, res_class, res_count
    );

    modport slave (
        input  cmd_valid, cmd, s_valid, s_data, res_ready,
        output cmd_ready, s_ready, res_valid, res_class, res_count
    );

endinterface

// File: rtl/snn_argmax.sv
// Combinational argmax over the output-neuron spike counters.
// Strict greater-than comparison keeps the lowest index on ties.
module snn_argmax
    import snn_pkg::*;
#(
    parameter int unsigned NUM_OUT = DEF_NUM_OUT,
    parameter int unsigned CNT_W   = DEF_CNT_W,
    localparam int unsigned CLS_W  = cls_width(NUM_OUT)
) (
    input  logic [NUM_OUT-1:0][CNT_W-1:0] counts_i,
    output logic [CLS_W-1:0]              class_o,
    output logic [CNT_W-1:0]              count_o
);

    logic [CLS_W-1:0] best_cls;
    logic [CNT_W-1:0] best_cnt;

    always_comb begin
        best_cls = '0;
        best_cnt = counts_i[0];
        for (int unsigned i = 1; i < NUM_OUT; i++) begin
            if (counts_i[i] > best_cnt) begin
                best_cls = CLS_W'(i);
                best_cnt = counts_i[i];
            end
        end
        class_o = best_cls;
        count_o = best_cnt;
    end

endmodule

// File: rtl/snn_sequencer.sv
// SNN sequencer: streams weights/inputs into the datapath, runs the network for a fixed number
// of timesteps and reports the argmax output neuron. SNN_SEQ_SETTLE_EN adds SETTLE uncounted cycles.
module snn_sequencer
    import snn_pkg::*;
#(
    parameter int unsigned INPUTS    = DEF_INPUTS,
    parameter int unsigned W_BYTES   = DEF_W_BYTES,
    parameter int unsigned NUM_OUT   = DEF_NUM_OUT,
    parameter int unsigned TIMESTEPS = DEF_TIMESTEPS,
    parameter int unsigned CNT_W     = DEF_CNT_W,
    parameter int unsigned SETTLE    = DEF_SETTLE
) (
    input  logic               clk,
    input  logic               rst_n,
    snn_sequencer_if.slave     bus,
    output logic [7:0]         dp_data,
    output logic               dp_input_weights,
    output logic               dp_execute,
    input  logic [NUM_OUT-1:0] dp_spikes,
    output logic               busy
);

    localparam int unsigned CLS_W    = cls_width(NUM_OUT);
    localparam int unsigned IN_BYTES = INPUTS / 8;
`ifdef SNN_SEQ_SETTLE_EN
    localparam int unsigned RUN_LEN  = TIMESTEPS + SETTLE;
`else
    localparam int unsigned RUN_LEN  = TIMESTEPS;
`endif
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e                        state_q;
    logic [15:0]                   byte_cnt_q;
    logic [15:0]                   run_cnt_q;
    logic [NUM_OUT-1:0][CNT_W-1:0] cnt_q;
    logic [NUM_OUT-1:0][CNT_W-1:0] cnt_inc;
    logic [NUM_OUT-1:0][CNT_W-1:0] cnt_d;
    logic                          res_valid_q;
    logic [CLS_W-1:0]              res_class_q;
    logic [CNT_W-1:0]              res_count_q;
    logic [CLS_W-1:0]              arg_class;
    logic [CNT_W-1:0]              arg_count;

    logic cmd_acc;
    logic byte_acc;
    logic load_last;
    logic run_last;
    logic count_en;

    always_comb begin
        cmd_acc   = (state_q == StIdle) && bus.cmd_valid;
        byte_acc  = ((state_q == StLoadW) || (state_q == StLoadIn)) && bus.s_valid;
        load_last = (state_q == StLoadW) ? (byte_cnt_q == 16'(W_BYTES - 1))
                                         : (byte_cnt_q == 16'(IN_BYTES - 1));
        run_last  = (run_cnt_q == 16'(RUN_LEN - 1));
`ifdef SNN_SEQ_SETTLE_EN
        count_en  = (run_cnt_q >= 16'(SETTLE));
`else
        count_en  = 1'b1;
`endif
        cnt_inc = cnt_q;
        for (int unsigned i = 0; i < NUM_OUT; i++) begin
            if (dp_spikes[i] && (cnt_q[i] != CNT_MAX)) begin
                cnt_inc[i] = cnt_q[i] + CNT_W'(1);
            end
        end
        cnt_d = count_en ? cnt_inc : cnt_q;
    end

    // Datapath only shifts on an accepted byte; otherwise the neurons advance.
    always_comb begin
        dp_execute       = !byte_acc;
        dp_data          = byte_acc ? bus.s_data : 8'h00;
        dp_input_weights = byte_acc && (state_q == StLoadW);
    end

    assign bus.cmd_ready = (state_q == StIdle);
    assign bus.s_ready   = (state_q == StLoadW) || (state_q == StLoadIn);
    assign busy          = (state_q != StIdle);
    assign bus.res_valid = res_valid_q;
    assign bus.res_class = res_class_q;
    assign bus.res_count = res_count_q;

    // Argmax sees this cycle's increments so the result is ready on DONE entry.
    snn_argmax #(
        .NUM_OUT (NUM_OUT),
        .CNT_W   (CNT_W)
    ) u_argmax (
        .counts_i (cnt_d),
        .class_o  (arg_class),
        .count_o  (arg_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            byte_cnt_q  <= '0;
            run_cnt_q   <= '0;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_class_q <= '0;
            res_count_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd_acc) begin
                        unique case (bus.cmd)
                            CMD_LOAD_W:  state_q <= StLoadW;
                            CMD_LOAD_IN: state_q <= StLoadIn;
                            CMD_RUN: begin
                                state_q   <= StRun;
                                run_cnt_q <= '0;
                                cnt_q     <= '0;
                            end
                            default: state_q <= StIdle;
                        endcase
                    end
                end
                StLoadW, StLoadIn: begin
                    if (byte_acc) begin
                        if (load_last) begin
                            byte_cnt_q <= '0;
                            state_q    <= StIdle;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 16'd1;
                        end
                    end
                end
                StRun: begin
                    cnt_q <= cnt_d;
                    if (run_last) begin
                        run_cnt_q   <= '0;
                        state_q     <= StDone;
                        res_valid_q <= 1'b1;
                        res_class_q <= arg_class;
                        res_count_q <= arg_count;
                    end else begin
                        run_cnt_q <= run_cnt_q + 16'd1;
                    end
                end
                StDone: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_snn_sequencer.sv
// Directed bench for snn_sequencer: two instances (CNT_W=4 and CNT_W=3) share stimulus and are
// checked every cycle against a transaction-level model, plus hand-computed literal results.
module tb_snn_sequencer;
    import snn_pkg::*;

    localparam int W_BYTES = 80;
`ifdef SNN_SEQ_SETTLE_EN
    localparam int RUN_LEN = 10;
    localparam int SKIP    = 2;
`else
    localparam int RUN_LEN = 8;
    localparam int SKIP    = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic       s_valid;
    logic [7:0] s_data;
    logic       res_ready;
    logic [7:0] spikes;

    logic [7:0] dp_data_a, dp_data_b;
    logic       dp_iw_a, dp_iw_b, dp_ex_a, dp_ex_b, busy_a, busy_b;

    int n_cmp = 0;
    int n_err = 0;

    snn_sequencer_if #(.NUM_OUT(8), .CNT_W(4)) bus_a ();
    snn_sequencer_if #(.NUM_OUT(8), .CNT_W(3)) bus_b ();

    assign bus_a.cmd_valid = cmd_valid;
    assign bus_a.cmd       = cmd;
    assign bus_a.s_valid   = s_valid;
    assign bus_a.s_data    = s_data;
    assign bus_a.res_ready = res_ready;
    assign bus_b.cmd_valid = cmd_valid;
    assign bus_b.cmd       = cmd;
    assign bus_b.s_valid   = s_valid;
    assign bus_b.s_data    = s_data;
    assign bus_b.res_ready = res_ready;

    snn_sequencer #(
        .INPUTS(16), .W_BYTES(80), .NUM_OUT(8), .TIMESTEPS(8), .CNT_W(4), .SETTLE(2)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a), .dp_data(dp_data_a), .dp_input_weights(dp_iw_a),
        .dp_execute(dp_ex_a), .dp_spikes(spikes), .busy(busy_a)
    );

    snn_sequencer #(
        .INPUTS(16), .W_BYTES(80), .NUM_OUT(8), .TIMESTEPS(8), .CNT_W(3), .SETTLE(2)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b), .dp_data(dp_data_b), .dp_input_weights(dp_iw_b),
        .dp_execute(dp_ex_b), .dp_spikes(spikes), .busy(busy_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: what the specification says the sequencer is doing.
    int mode;          // 0 idle, 1 loading weights, 2 loading inputs, 3 running, 4 result held
    int bytes_left;
    int cyc;
    int ca[8];
    int cb[8];
    int ra_cls, ra_cnt, rb_cls, rb_cnt;
    int xfer_cnt, xfer_w_cnt;

    task automatic chk_outs(input string t, input logic cr, input logic sr, input logic ex,
                            input logic [7:0] d, input logic iw, input logic bz, input logic rv,
                            input logic [2:0] rc, input logic [3:0] rn, input bit in_rst,
                            input int ecls, input int ecnt);
        bit acc;
        acc = (mode == 1 || mode == 2) && s_valid;
        chk({t, "_cmd_ready"}, cr, (in_rst || mode == 0));
        chk({t, "_s_ready"}, sr, (!in_rst && (mode == 1 || mode == 2)));
        chk({t, "_dp_execute"}, ex, (in_rst || !acc));
        chk({t, "_dp_data"}, d, (!in_rst && acc) ? s_data : 8'h00);
        chk({t, "_dp_iw"}, iw, (!in_rst && acc && mode == 1));
        chk({t, "_busy"}, bz, (!in_rst && mode != 0));
        chk({t, "_res_valid"}, rv, (!in_rst && mode == 4));
        if (in_rst || mode == 4) begin
            chk({t, "_res_class"}, rc, ecls);
            chk({t, "_res_count"}, rn, ecnt);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mode = 0; bytes_left = 0; cyc = 0;
                ra_cls = 0; ra_cnt = 0; rb_cls = 0; rb_cnt = 0;
                for (int i = 0; i < 8; i++) begin ca[i] = 0; cb[i] = 0; end
                chk_outs("rstA", bus_a.cmd_ready, bus_a.s_ready, dp_ex_a, dp_data_a, dp_iw_a,
                         busy_a, bus_a.res_valid, bus_a.res_class, bus_a.res_count, 1'b1, 0, 0);
                chk_outs("rstB", bus_b.cmd_ready, bus_b.s_ready, dp_ex_b, dp_data_b, dp_iw_b,
                         busy_b, bus_b.res_valid, bus_b.res_class, {1'b0, bus_b.res_count},
                         1'b1, 0, 0);
            end else begin
                chk_outs("A", bus_a.cmd_ready, bus_a.s_ready, dp_ex_a, dp_data_a, dp_iw_a,
                         busy_a, bus_a.res_valid, bus_a.res_class, bus_a.res_count, 1'b0,
                         ra_cls, ra_cnt);
                chk_outs("B", bus_b.cmd_ready, bus_b.s_ready, dp_ex_b, dp_data_b, dp_iw_b,
                         busy_b, bus_b.res_valid, bus_b.res_class, {1'b0, bus_b.res_count},
                         1'b0, rb_cls, rb_cnt);
                if (!dp_ex_a) begin
                    xfer_cnt++;
                    if (dp_iw_a) xfer_w_cnt++;
                end
                // Advance the model by what the coming rising edge will accept.
                case (mode)
                    0: if (cmd_valid) begin
                        case (cmd)
                            2'b00: begin mode = 1; bytes_left = W_BYTES; end
                            2'b01: begin mode = 2; bytes_left = 2; end
                            2'b10: begin
                                mode = 3; cyc = 0;
                                for (int i = 0; i < 8; i++) begin ca[i] = 0; cb[i] = 0; end
                            end
                            default: ;
                        endcase
                    end
                    1, 2: if (s_valid) begin
                        bytes_left--;
                        if (bytes_left == 0) mode = 0;
                    end
                    3: begin
                        if (cyc >= SKIP) begin
                            for (int i = 0; i < 8; i++) begin
                                if (spikes[i]) begin
                                    if (ca[i] < 15) ca[i]++;
                                    if (cb[i] < 7) cb[i]++;
                                end
                            end
                        end
                        cyc++;
                        if (cyc == RUN_LEN) begin
                            ra_cls = 0; ra_cnt = ca[0]; rb_cls = 0; rb_cnt = cb[0];
                            for (int i = 1; i < 8; i++) begin
                                if (ca[i] > ra_cnt) begin ra_cls = i; ra_cnt = ca[i]; end
                                if (cb[i] > rb_cnt) begin rb_cls = i; rb_cnt = cb[i]; end
                            end
                            mode = 4;
                        end
                    end
                    4: if (res_ready) mode = 0;
                    default: ;
                endcase
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1);
    end

    task automatic send_cmd(input logic [1:0] c);
        int n;
        cmd = c; cmd_valid = 1'b1; n = 0;
        while (!bus_a.cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (!bus_a.cmd_ready) chk("cmd_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd = CMD_NOP;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        s_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        s_data = b; s_valid = 1'b1; n = 0;
        while (!bus_a.s_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (!bus_a.s_ready) chk("byte_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    // Returns the number of RUN cycles seen before the result appeared.
    task automatic do_run(input logic [7:0] pat, input int nhigh, output int k);
        spikes = pat;
        send_cmd(CMD_RUN);
        k = 0;
        while (k < 100) begin
            @(posedge clk); #1;
            k++;
            if (k == nhigh) spikes = 8'h00;
            if (bus_a.res_valid) break;
        end
        if (!bus_a.res_valid) chk("run_timeout", 32'd0, 32'd1);
    endtask

    task automatic release_res();
        @(posedge clk); #1; res_ready = 1'b1;
        @(posedge clk); #1; res_ready = 1'b0;
    endtask

    initial begin
        int k;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd = CMD_NOP; s_valid = 1'b0; s_data = 8'h00;
        res_ready = 1'b0; spikes = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Weight load, 80 back-to-back bytes.
        xfer_cnt = 0; xfer_w_cnt = 0;
        send_cmd(CMD_LOAD_W);
        for (int i = 0; i < 80; i++) send_byte(8'(i), 0);
        chk("lw_xfers", xfer_cnt, 80);
        chk("lw_weight_xfers", xfer_w_cnt, 80);
        chk("lw_idle", bus_a.cmd_ready, 1);

        // Input load with a 3-cycle stall between the two bytes.
        xfer_cnt = 0; xfer_w_cnt = 0;
        send_cmd(CMD_LOAD_IN);
        send_byte(8'hA5, 0);
        send_byte(8'h3C, 3);
        chk("li_xfers", xfer_cnt, 2);
        chk("li_weight_xfers", xfer_w_cnt, 0);
        chk("li_idle", busy_a, 0);

        // Neuron 2 always fires.
        do_run(8'h04, 0, k);
        chk("run_len", k, RUN_LEN);
        chk("r1_class_a", bus_a.res_class, 2);
        chk("r1_count_a", bus_a.res_count, 8);
        chk("r1_class_b", bus_b.res_class, 2);
        chk("r1_count_b", bus_b.res_count, 7);
        release_res();
        chk("r1_back_idle", bus_a.res_valid, 0);

        // Neurons 1 and 5 tie; narrow counters saturate.
        do_run(8'h22, 0, k);
        chk("r2_class_a", bus_a.res_class, 1);
        chk("r2_count_a", bus_a.res_count, 8);
        chk("r2_class_b", bus_b.res_class, 1);
        chk("r2_count_b", bus_b.res_count, 7);
        release_res();

        // Reset mid-run clears results and returns to idle at once.
        spikes = 8'hFF;
        send_cmd(CMD_RUN);
        repeat (4) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("mr_busy", busy_a, 0);
        chk("mr_class", bus_a.res_class, 0);
        @(posedge clk); #1;
        rst_n = 1'b1; spikes = 8'h00;
        @(posedge clk); #1;

        // No spikes at all.
        do_run(8'h00, 0, k);
        chk("r3_class_a", bus_a.res_class, 0);
        chk("r3_count_a", bus_a.res_count, 0);
        release_res();

        // Neuron 0 fires only on the first two RUN cycles.
        do_run(8'h01, 2, k);
        chk("r4_class_a", bus_a.res_class, 0);
`ifdef SNN_SEQ_SETTLE_EN
        chk("r4_count_a", bus_a.res_count, 0);
`else
        chk("r4_count_a", bus_a.res_count, 2);
`endif
        release_res();

        // Reset at the 40th weight byte, then a full fresh load.
        send_cmd(CMD_LOAD_W);
        for (int i = 0; i < 39; i++) send_byte(8'(i), 0);
        s_data = 8'h27; s_valid = 1'b1; rst_n = 1'b0;
        @(posedge clk); #1;
        s_valid = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;
        xfer_cnt = 0;
        send_cmd(CMD_LOAD_W);
        for (int i = 0; i < 79; i++) send_byte(8'(8'hFF - i), 0);
        chk("rl_still_loading", busy_a, 1);
        send_byte(8'h11, 1);
        chk("rl_idle", bus_a.cmd_ready, 1);
        chk("rl_xfers", xfer_cnt, 80);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
